// File: rtl/fm_pkg.sv
// Shared types and defaults for the FM protocol stimulus generator.
package fm_pkg;

   localparam int unsigned FM_DLY_W_DEF = 4;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      RISE_A = 3'd1,
      WAIT_B = 3'd2,
      WAIT_D = 3'd3,
      GAP    = 3'd4
   } fm_state_t;

endpackage

// File: rtl/fm_dly_cnt.sv
// Loadable saturating down-counter with a registered zero flag.
module fm_dly_cnt #(
   parameter int unsigned CNT_W = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load_i,
   input  logic [CNT_W-1:0] load_val_i,
   input  logic             dec_i,
   output logic             zero_o
);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             zero_q;

   // Load wins over decrement; the count stops at zero instead of wrapping.
   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = load_val_i;
      end else if (dec_i && (cnt_q != '0)) begin
         cnt_d = cnt_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q  <= '0;
         zero_q <= 1'b1;
      end else begin
         cnt_q  <= cnt_d;
         zero_q <= (cnt_d == '0);
      end
   end

   assign zero_o = zero_q;

endmodule

// File: rtl/fm_stim_gen.sv
// Generates one a/b/d/e stimulus sequence per accepted start, with
// programmable a->b and b->d spacing and an optional missing-e fault.
module fm_stim_gen
   import fm_pkg::*;
#(
   parameter int unsigned DLY_W = FM_DLY_W_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [DLY_W-1:0] dly_b,
   input  logic [DLY_W-1:0] dly_d,
   input  logic             inject_err,
   output logic             a,
   output logic             b,
   output logic             d,
   output logic             e,
   output logic             busy,
   output logic             done
);

   localparam int unsigned CNT_W = DLY_W + 1;

   fm_state_t        state_q, state_d;
   logic [DLY_W-1:0] dly_d_q, dly_d_d;
   logic             err_q, err_d;
   logic             a_q, a_d;
   logic             b_q, b_d;
   logic             d_q, d_d;
   logic             e_q, e_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;

   logic             cnt_load;
   logic             cnt_dec;
   logic             cnt_zero;
   logic [CNT_W-1:0] cnt_val;
   logic [CNT_W-1:0] b_load_c;

   // The cycle of a itself counts as the first step towards b, so a zero
   // delay behaves like one.
   assign b_load_c = (dly_b == '0) ? '0 : (CNT_W'(dly_b) - CNT_W'(1));

   fm_dly_cnt #(
      .CNT_W (CNT_W)
   ) u_dly_cnt (
      .clk        (clk),
      .rst        (rst),
      .load_i     (cnt_load),
      .load_val_i (cnt_val),
      .dec_i      (cnt_dec),
      .zero_o     (cnt_zero)
   );

   always_comb begin
      state_d  = state_q;
      dly_d_d  = dly_d_q;
      err_d    = err_q;
      a_d      = 1'b0;
      b_d      = 1'b0;
      d_d      = 1'b0;
      e_d      = 1'b0;
      busy_d   = 1'b0;
      done_d   = 1'b0;
      cnt_load = 1'b0;
      cnt_dec  = 1'b0;
      cnt_val  = '0;

      case (state_q)
         IDLE: begin
            if (start) begin
               state_d  = RISE_A;
               dly_d_d  = dly_d;
               err_d    = inject_err;
               a_d      = 1'b1;
               busy_d   = 1'b1;
               cnt_load = 1'b1;
               cnt_val  = b_load_c;
            end
         end

         RISE_A, WAIT_B: begin
            a_d    = 1'b1;
            busy_d = 1'b1;
            if (cnt_zero) begin
               state_d  = WAIT_D;
               b_d      = 1'b1;
               cnt_load = 1'b1;
               cnt_val  = CNT_W'(dly_d_q);
            end else begin
               state_d = WAIT_B;
               cnt_dec = 1'b1;
            end
         end

         // Counter parks at zero for the d cycle; d_q marks that d was issued.
         WAIT_D: begin
            busy_d = 1'b1;
            if (cnt_zero && d_q) begin
               state_d = GAP;
            end else if (cnt_zero) begin
               a_d    = 1'b1;
               d_d    = 1'b1;
               e_d    = ~err_q;
               done_d = 1'b1;
            end else begin
               a_d     = 1'b1;
               cnt_dec = 1'b1;
            end
         end

         GAP: begin
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         dly_d_q <= '0;
         err_q   <= 1'b0;
         a_q     <= 1'b0;
         b_q     <= 1'b0;
         d_q     <= 1'b0;
         e_q     <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         dly_d_q <= dly_d_d;
         err_q   <= err_d;
         a_q     <= a_d;
         b_q     <= b_d;
         d_q     <= d_d;
         e_q     <= e_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign a    = a_q;
   assign b    = b_q;
   assign d    = d_q;
   assign e    = e_q;
   assign busy = busy_q;
   assign done = done_q;

endmodule

// File: tb/tb_fm_stim_gen.sv
// Directed bench for fm_stim_gen: per-cycle timeline model plus literal timing pins.
module tb_fm_stim_gen;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic [3:0] dly_b = 4'd0;
   logic [3:0] dly_d = 4'd0;
   logic       inject_err = 1'b0;
   logic       a, b, d, e, busy, done;

   fm_stim_gen #(.DLY_W(4)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .dly_b      (dly_b),
      .dly_d      (dly_d),
      .inject_err (inject_err),
      .a          (a),
      .b          (b),
      .d          (d),
      .e          (e),
      .busy       (busy),
      .done       (done)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_checks = 0;
   int n_errs   = 0;
   bit chk_en   = 1'b0;

   // Timeline model: one sequence at a time, described by its key cycles.
   bit seq_v   = 1'b0;
   int s_t     = 0;
   int s_b     = 0;
   int s_d     = 0;
   bit s_err   = 1'b0;
   int free_at = 0;

   int   n_e = 0, n_d = 0, n_done = 0;
   int   last_b = -1, last_d = -1, last_busy_fall = -1;
   int   a_rises[$];
   logic prev_a = 1'b0, prev_busy = 1'b0;
   logic [5:0] act_v, exp_v;

   always @(negedge clk) begin
      act_v = {a, b, d, e, busy, done};
      exp_v = '0;
      if (seq_v) begin
         exp_v[5] = (cyc >= s_t) && (cyc <= s_d);
         exp_v[4] = (cyc == s_b);
         exp_v[3] = (cyc == s_d);
         exp_v[2] = (cyc == s_d) && !s_err;
         exp_v[1] = (cyc >= s_t) && (cyc <= s_d + 1);
         exp_v[0] = (cyc == s_d);
      end
      if (chk_en) begin
         n_checks++;
         if (act_v !== exp_v) begin
            n_errs++;
            $display("FAIL outputs cyc=%0d {a,b,d,e,busy,done} got=%b exp=%b", cyc, act_v, exp_v);
         end
      end
      if (rst) begin
         seq_v   = 1'b0;
         free_at = cyc + 1;
      end else if (start && (cyc >= free_at)) begin
         s_t     = cyc + 1;
         s_b     = s_t + ((dly_b == 4'd0) ? 1 : int'(dly_b));
         s_d     = s_b + 1 + int'(dly_d);
         s_err   = inject_err;
         seq_v   = 1'b1;
         free_at = s_d + 2;
      end
      if (b === 1'b1) last_b = cyc;
      if (d === 1'b1) begin n_d++; last_d = cyc; end
      if (e === 1'b1) n_e++;
      if (done === 1'b1) n_done++;
      if ((a === 1'b1) && (prev_a === 1'b0)) a_rises.push_back(cyc);
      if ((busy === 1'b0) && (prev_busy === 1'b1)) last_busy_fall = cyc;
      prev_a    = a;
      prev_busy = busy;
   end

   task automatic chk(input string nm, input int act, input int expv);
      n_checks++;
      if (act != expv) begin
         n_errs++;
         $display("FAIL %s got=%0d exp=%0d", nm, act, expv);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_start(input int db, input int dd, input bit err, output int c0);
      dly_b      = 4'(db);
      dly_d      = 4'(dd);
      inject_err = err;
      start      = 1'b1;
      c0         = cyc;
      tick(1);
      start      = 1'b0;
   endtask

   int c0, e0, d0, done0, r0;

   initial begin
      tick(1);
      chk_en = 1'b1;
      tick(2);
      rst = 1'b0;
      chk("reset_outputs", int'({a, b, d, e, busy, done}), 0);

      // dly_b=3, dly_d=2: b at +4, d/e/done at +7, busy low at +9
      e0 = n_e;
      do_start(3, 2, 1'b0, c0);
      tick(10);
      chk("t1_a_rise", a_rises[$] - c0, 1);
      chk("t1_b_at", last_b - c0, 4);
      chk("t1_d_at", last_d - c0, 7);
      chk("t1_busy_fall", last_busy_fall - c0, 9);
      chk("t1_e_count", n_e - e0, 1);

      // zero delays: b at T+1, d at T+2
      do_start(0, 0, 1'b0, c0);
      tick(6);
      chk("t2_b_at", last_b - c0, 2);
      chk("t2_d_at", last_d - c0, 3);
      chk("t2_busy_fall", last_busy_fall - c0, 5);

      // injected error: d at T+4 with no e, done still pulses once
      e0 = n_e; done0 = n_done;
      do_start(2, 1, 1'b1, c0);
      tick(8);
      chk("t3_d_at", last_d - c0, 5);
      chk("t3_e_count", n_e - e0, 0);
      chk("t3_done_count", n_done - done0, 1);

      // reset two cycles before d aborts the sequence
      d0 = n_d; done0 = n_done;
      do_start(1, 5, 1'b0, c0);
      tick(5);
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      chk("t4_outputs_cleared", int'({a, b, d, e, busy, done}), 0);
      tick(6);
      chk("t4_no_d", n_d - d0, 0);
      chk("t4_no_done", n_done - done0, 0);
      do_start(1, 0, 1'b0, c0);
      tick(5);
      chk("t4_restart_d_at", last_d - c0, 3);

      // start during the gap cycle is ignored
      do_start(2, 1, 1'b0, c0);
      tick(5);
      start = 1'b1;
      tick(1);
      start = 1'b0;
      tick(6);
      chk("t5_single_rise", a_rises[$] - c0, 1);
      chk("t5_busy_fall", last_busy_fall - c0, 7);

      // extreme delays
      do_start(15, 0, 1'b0, c0);
      tick(20);
      chk("t6a_d_at", last_d - c0, 17);
      do_start(1, 15, 1'b0, c0);
      tick(21);
      chk("t6b_b_at", last_b - c0, 2);
      chk("t6b_d_at", last_d - c0, 18);

      // start held high with maximum delays: back-to-back sequences
      dly_b = 4'd15;
      dly_d = 4'd15;
      inject_err = 1'b0;
      r0 = a_rises.size();
      start = 1'b1;
      c0 = cyc;
      tick(110);
      start = 1'b0;
      tick(40);
      chk("t7_rise_count", a_rises.size() - r0, 4);
      if (a_rises.size() - r0 >= 3) begin
         chk("t7_first_rise", a_rises[r0] - c0, 1);
         chk("t7_period_1", a_rises[r0 + 1] - a_rises[r0], 34);
         chk("t7_period_2", a_rises[r0 + 2] - a_rises[r0 + 1], 34);
      end
      chk("t7_last_d", last_d - c0, 134);
      chk("t7_idle_at_end", int'(busy), 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
      $finish;
   end

endmodule
